// File: rtl/sr_pkg.sv
// Shared types and defaults for the SR input conditioner.
// Optional feature macro used by the channel: SR_INPUT_CONDITIONER_SYNC_EN.
package sr_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } chan_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000;
  localparam int unsigned CNT_W_DEFAULT           = 16;

endpackage

// File: rtl/sr_debounce_channel.sv
// One debounce channel: optional two-flop synchronizer, four-state debounce FSM with a
// saturating counter, and rising-level detection.
// Macro SR_INPUT_CONDITIONER_SYNC_EN inserts the synchronizer (adds two cycles of latency).
// DEBOUNCE_CYCLES must be >= 2 and 2**CNT_W must exceed DEBOUNCE_CYCLES.
module sr_debounce_channel
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  // High in the cycle before the edge on which o_level rises; the top registers it.
  output logic o_rise
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             w_sample;
  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_level;

`ifdef SR_INPUT_CONDITIONER_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  assign w_sample = r_sync[1];
`else
  assign w_sample = i_raw;
`endif

  // Counter never wraps, even if the FSM were to stay in a counting state.
  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CntOne;

  // Debounce FSM: level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_sample) begin
            r_state <= ARMING;
            r_cnt   <= CntOne;
          end
        end
        ARMING: begin
          if (!w_sample) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CntLast) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_level <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HELD: begin
          if (!w_sample) begin
            r_state <= RELEASING;
            r_cnt   <= CntOne;
          end
        end
        RELEASING: begin
          if (w_sample) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CntLast) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_rise  = (r_state == ARMING) && w_sample && (r_cnt == CntLast);

endmodule

// File: rtl/sr_input_conditioner.sv
// Conditions two bouncy buttons into clean, mutually exclusive set/reset pulses for an SR latch.
// Optional synchronizers in each channel are enabled by SR_INPUT_CONDITIONER_SYNC_EN.
module sr_input_conditioner
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic s_raw,
  input  logic r_raw,
  output logic s,
  output logic r,
  output logic s_db,
  output logic r_db,
  output logic invalid
);

  logic w_s_rise;
  logic w_r_rise;
  logic r_s;
  logic r_r;
  logic r_invalid;

  sr_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_ch (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (s_raw),
    .o_level(s_db),
    .o_rise (w_s_rise)
  );

  sr_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_reset_ch (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (r_raw),
    .o_level(r_db),
    .o_rise (w_r_rise)
  );

  // Mutual exclusion: a simultaneous rise suppresses both pulses and flags invalid instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_s       <= w_s_rise & ~w_r_rise;
      r_r       <= w_r_rise & ~w_s_rise;
      r_invalid <= w_s_rise & w_r_rise;
    end
  end

  assign s       = r_s;
  assign r       = r_r;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner with DEBOUNCE_CYCLES=4. Stimulus tables are rebuilt per scenario;
// expected outputs go through a scoreboard queue and are compared one edge later.
module tb_sr_input_conditioner;

  localparam int unsigned D = 4;
`ifdef SR_INPUT_CONDITIONER_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif
  // Edge index (0 = first edge sampling the new input) on which a pulse appears.
  localparam int P = D - 1 + SyncLat;

  typedef struct packed {
    logic s;
    logic r;
    logic s_db;
    logic r_db;
    logic inv;
  } out_t;

  typedef struct {
    logic s_raw;
    logic r_raw;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_raw = 1'b0;
  logic r_raw = 1'b0;
  logic s, r, s_db, r_db, invalid;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  sr_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_raw  (s_raw),
    .r_raw  (r_raw),
    .s      (s),
    .r      (r),
    .s_db   (s_db),
    .r_db   (r_db),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic sr, logic rr, logic es, logic er, logic esdb, logic erdb,
                              logic einv);
    vec_t v;
    v.s_raw = sr;
    v.r_raw = rr;
    v.exp   = '{s: es, r: er, s_db: esdb, r_db: erdb, inv: einv};
    return v;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o = '{s: s, r: r, s_db: s_db, r_db: r_db, inv: invalid};
    return o;
  endfunction

  task automatic check(input string name, input int row, input out_t got, input out_t exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s row %0d: got {s,r,s_db,r_db,inv}=%b, expected %b", name, row, got, exp);
    end
  endtask

  // Called at a negedge: drive one row, push its expectation, compare after the next edge.
  task automatic step(input string name, input int row, input vec_t v);
    out_t exp;
    s_raw = v.s_raw;
    r_raw = v.r_raw;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(name, row, dut_out(), exp);
    @(negedge clk);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      step(name, i, tbl[i]);
    end
    tbl.delete();
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string name);
    rst   = 1'b1;
    s_raw = 1'b0;
    r_raw = 1'b0;
    #1;
    check(name, 0, dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check("reset_state", 0, dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Steady set press, then release: one pulse on rise, none on fall.
    for (int i = 0; i < 16; i++) begin
      tbl.push_back(mk(i < 8, 1'b0, i == P, 1'b0, (i >= P) && (i < 8 + P), 1'b0, 1'b0));
    end
    run_table("set_hold_release");
    do_reset("reset_after_release");

    // Bounce 1,1,0 then steady 1: count restarts after the 0.
    for (int i = 0; i < 12; i++) begin
      tbl.push_back(mk(i != 2, 1'b0, i == P + 3, 1'b0, i >= P + 3, 1'b0, 1'b0));
    end
    run_table("set_bounce");
    do_reset("reset_from_held");

    // Both buttons rise together: pulses suppressed, invalid for one cycle, levels still rise.
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, i >= P, i >= P, i == P));
    end
    run_table("simultaneous");
    do_reset("reset_both_held");

    // Reset channel alone.
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, i == P, 1'b0, i >= P, 1'b0));
    end
    run_table("reset_hold");
    do_reset("reset_after_r");

    // Staggered presses: each pulse stands alone, never overlapping.
    for (int i = 0; i < 14; i++) begin
      tbl.push_back(mk(1'b1, i >= 6, i == P, i == 6 + P, i >= P, i >= 6 + P, 1'b0));
    end
    run_table("staggered");
    do_reset("reset_after_stagger");

    // Reset in the middle of arming discards the partial count.
    s_raw = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1 check("rst_mid_arming", 0, dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b1, 1'b0, i == P, 1'b0, i >= P, 1'b0, 1'b0));
    end
    run_table("after_mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
